// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared 7-segment code table, blank code and reader FSM states
package seven_segment_pkg;

    localparam logic [6:0] SEG_BLANK_N = 7'h7F;

    typedef enum logic {
        SETTLING,
        HELD
    } seg_state_e;

    // Active-low codes, bit6=g .. bit0=a; the encoder draws from the same table.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h18;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seven_segment_decode.sv
// rtl/seven_segment_decode.sv - combinational active-low segment pattern to hex/blank/error
module seven_segment_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] hex,
    output logic       is_blank,
    output logic       is_err
);

    logic hit;

    always_comb begin
        hex = 4'h0;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == seg_encode(4'(i))) begin
                hex = 4'(i);
                hit = 1'b1;
            end
        end
        is_blank = (seg_n == SEG_BLANK_N);
        is_err   = !hit && !is_blank;
    end

endmodule

// File: rtl/seven_segment_reader.sv
// rtl/seven_segment_reader.sv - samples a multiplexed 7-segment bus and publishes whole frames
module seven_segment_reader
    import seven_segment_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_n,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     blank_mask,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  valid,
    output logic                  frame_done
);

    localparam int SW = 7 + DIGITS;
    localparam int CW = $clog2(SETTLE) + 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

    logic [SW-1:0]       sync1_q, sync2_q, s_q;
    logic [CW-1:0]       stable_cnt_q, stable_cnt_d;
    seg_state_e          state_q, state_d;
    logic [4*DIGITS-1:0] shadow_value_q, shadow_value_d;
    logic [DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [DIGITS-1:0]   blank_q, blank_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                valid_q, valid_d;
    logic                frame_done_q, frame_done_d;

    logic [3:0]          dec_hex;
    logic                dec_blank, dec_err;
    logic                s_change, stable, capture, complete;
    logic [DIGITS-1:0]   dig_low, seen_next;

    seven_segment_decode u_decode (
        .seg_n    (s_q[6:0]),
        .hex      (dec_hex),
        .is_blank (dec_blank),
        .is_err   (dec_err)
    );

    always_comb begin
        s_change = (sync2_q != s_q);
        stable   = (stable_cnt_q == CNT_MAX);
        dig_low  = ~s_q[SW-1:7];
        capture  = (state_q == SETTLING) && stable && $onehot(dig_low);

        stable_cnt_d = s_change ? '0 : (stable ? stable_cnt_q : stable_cnt_q + CW'(1));

        // A capture coinciding with a new sample must stay armed for that new sample.
        state_d = state_q;
        case (state_q)
            SETTLING: if (capture && !s_change) state_d = HELD;
            HELD:     if (s_change)             state_d = SETTLING;
            default:  state_d = SETTLING;
        endcase

        shadow_value_d = shadow_value_q;
        shadow_blank_d = shadow_blank_q;
        shadow_err_d   = shadow_err_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && dig_low[i]) begin
                shadow_value_d[4*i +: 4] = dec_hex;
                shadow_blank_d[i]        = dec_blank;
                shadow_err_d[i]          = dec_err;
            end
        end
        seen_next = seen_q | (capture ? dig_low : '0);
        complete  = capture && (&seen_next);

        value_d      = value_q;
        blank_d      = blank_q;
        err_d        = err_q;
        valid_d      = valid_q;
        frame_done_d = complete;
        seen_d       = seen_next;
        tmo_d        = tmo_q + TW'(1);
        if (complete) begin
            value_d = shadow_value_d;
            blank_d = shadow_blank_d;
            err_d   = shadow_err_d;
            valid_d = 1'b1;
            seen_d  = '0;
            tmo_d   = '0;
        end else if (tmo_q == TMO_MAX) begin
            valid_d = 1'b0;
            seen_d  = capture ? dig_low : '0;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= '1;
            sync2_q        <= '1;
            s_q            <= '1;
            stable_cnt_q   <= '0;
            state_q        <= SETTLING;
            shadow_value_q <= '0;
            shadow_blank_q <= '0;
            shadow_err_q   <= '0;
            seen_q         <= '0;
            tmo_q          <= '0;
            value_q        <= '0;
            blank_q        <= '0;
            err_q          <= '0;
            valid_q        <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            sync1_q        <= {dig_n, seg_n};
            sync2_q        <= sync1_q;
            s_q            <= sync2_q;
            stable_cnt_q   <= stable_cnt_d;
            state_q        <= state_d;
            shadow_value_q <= shadow_value_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_err_q   <= shadow_err_d;
            seen_q         <= seen_d;
            tmo_q          <= tmo_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            err_q          <= err_d;
            valid_q        <= valid_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign value      = value_q;
    assign blank_mask = blank_q;
    assign err_mask   = err_q;
    assign valid      = valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// tb/tb_seven_segment_reader.sv - directed bench with per-cycle behavioural model for seven_segment_reader
module tb_seven_segment_reader;

    localparam int ND  = 4;
    localparam int ST  = 4;
    localparam int TMO = 300;

    logic        clk;
    logic        reset;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        valid;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int fd_count = 0;

    seven_segment_reader #(.DIGITS(ND), .SETTLE(ST), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_n      (seg_n),
        .dig_n      (dig_n),
        .value      (value),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .valid      (valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the pins reach the sample stream two edges late; a sample is
    // captured once, when its run of identical samples first reaches ST.
    logic [10:0] m_sy1, m_sy2, m_x;
    int          m_run;
    logic [3:0]  m_sh_val [ND];
    bit          m_sh_blank [ND];
    bit          m_sh_err [ND];
    bit          m_seen [ND];
    logic [15:0] m_value;
    logic [3:0]  m_blank, m_err;
    bit          m_valid, m_fd, m_live = 0;
    int          m_tmo;

    always @(posedge clk) begin : model
        bit cap, all_seen, found;
        int k;
        logic [3:0] low;
        if (reset) begin
            m_sy1 = '1; m_sy2 = '1; m_x = '1; m_run = 1;
            for (int i = 0; i < ND; i++) begin
                m_sh_val[i] = 0; m_sh_blank[i] = 0; m_sh_err[i] = 0; m_seen[i] = 0;
            end
            m_value = 0; m_blank = 0; m_err = 0; m_valid = 0; m_fd = 0; m_tmo = 0;
            m_live = 1;
        end else begin
            low = ~m_x[10:7];
            cap = (m_run == ST) && ($countones(low) == 1);
            k = 0;
            for (int i = 0; i < ND; i++) if (low[i]) k = i;
            m_fd = 0;
            if (cap) begin
                found = 0;
                m_sh_val[k] = 0; m_sh_blank[k] = 0; m_sh_err[k] = 0;
                for (int v = 0; v < 16; v++)
                    if (m_x[6:0] == seg_tab[v]) begin m_sh_val[k] = 4'(v); found = 1; end
                if (m_x[6:0] == 7'h7F) m_sh_blank[k] = 1;
                else if (!found) m_sh_err[k] = 1;
                m_seen[k] = 1;
            end
            all_seen = 1;
            for (int i = 0; i < ND; i++) all_seen &= m_seen[i];
            if (cap && all_seen) begin
                for (int i = 0; i < ND; i++) begin
                    m_value[4*i +: 4] = m_sh_val[i];
                    m_blank[i] = m_sh_blank[i];
                    m_err[i] = m_sh_err[i];
                    m_seen[i] = 0;
                end
                m_fd = 1; m_valid = 1; m_tmo = 0;
            end else if (m_tmo == TMO - 1) begin
                m_valid = 0; m_tmo = 0;
                for (int i = 0; i < ND; i++) m_seen[i] = 0;
                if (cap) m_seen[k] = 1;
            end else begin
                m_tmo++;
            end
            m_run = (m_sy2 == m_x) ? m_run + 1 : 1;
            m_x = m_sy2; m_sy2 = m_sy1; m_sy1 = {dig_n, seg_n};
        end
        if (frame_done === 1'b1) fd_count++;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_value", 32'(value), 32'(m_value));
            chk("cyc_blank", 32'(blank_mask), 32'(m_blank));
            chk("cyc_err", 32'(err_mask), 32'(m_err));
            chk("cyc_valid", 32'(valid), 32'(m_valid));
            chk("cyc_frame_done", 32'(frame_done), 32'(m_fd));
        end
    end

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        seg_n = s;
        dig_n = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int dig, input logic [6:0] s, input int n);
        logic [3:0] one;
        one = 4'b0001 << dig;
        drive(s, ~one, n);
    endtask

    task automatic idle(input int n);
        drive(7'h7F, 4'hF, n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        int fd0, n, got;
        reset = 1'b1;
        seg_n = 7'h7F;
        dig_n = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_value", 32'(value), 0);
        chk("rst_blank", 32'(blank_mask), 0);
        chk("rst_err", 32'(err_mask), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        reset = 1'b0;
        idle(8);

        // Basic frame: digit3..0 = 4,3,2,1
        fd0 = fd_count;
        show(3, 7'h19, 10); show(2, 7'h30, 10); show(1, 7'h24, 10); show(0, 7'h79, 10);
        idle(4);
        chk("f1_pulses", 32'(fd_count - fd0), 1);
        chk("f1_value", 32'(value), 32'h4321);
        chk("f1_valid", 32'(valid), 1);
        chk("f1_blank", 32'(blank_mask), 0);
        chk("f1_err", 32'(err_mask), 0);

        // One digit held long: no frame until the others are shown
        fd0 = fd_count;
        show(2, 7'h12, 200);
        chk("hold_no_pulse", 32'(fd_count - fd0), 0);
        show(3, 7'h02, 10); show(1, 7'h78, 10); show(0, 7'h00, 10);
        idle(4);
        chk("hold_pulses", 32'(fd_count - fd0), 1);
        chk("hold_value", 32'(value), 32'h6578);

        // Glitches before the last digit must not capture it
        fd0 = fd_count;
        show(3, 7'h18, 10); show(2, 7'h08, 10); show(1, 7'h03, 10);
        drive(7'h03, 4'b1100, 2);
        show(0, 7'h46, 3); show(0, 7'h06, 3); show(0, 7'h46, 3); show(0, 7'h06, 3);
        idle(5);
        chk("glitch_no_pulse", 32'(fd_count - fd0), 0);
        show(0, 7'h46, 10);
        idle(4);
        chk("glitch_pulses", 32'(fd_count - fd0), 1);
        chk("glitch_value", 32'(value), 32'h9ABC);

        // Blank and error digits, then timeout measured from the frame_done pulse
        show(3, 7'h19, 10); show(2, 7'h7F, 10); show(1, 7'h55, 10);
        seg_n = 7'h79; dig_n = 4'b1110;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (got == 0 && frame_done === 1'b1) got = 1;
            if (got == 1) c = 30;
        end
        chk("mask_pulse_seen", 32'(got), 1);
        chk("mask_value", 32'(value), 32'h4001);
        chk("mask_blank", 32'(blank_mask), 32'h4);
        chk("mask_err", 32'(err_mask), 32'h2);
        n = 0;
        for (int c = 1; c <= TMO + 20; c++) begin
            @(negedge clk);
            if (n == 0 && valid !== 1'b1) n = c;
        end
        chk("tmo_cycle", 32'(n), 32'(TMO));
        chk("tmo_valid", 32'(valid), 0);
        chk("tmo_value_held", 32'(value), 32'h4001);
        chk("tmo_blank_held", 32'(blank_mask), 32'h4);
        show(3, 7'h21, 10); show(2, 7'h06, 10); show(1, 7'h0E, 10); show(0, 7'h40, 10);
        idle(4);
        chk("resume_valid", 32'(valid), 1);
        chk("resume_value", 32'(value), 32'hDEF0);
        chk("resume_masks", 32'({blank_mask, err_mask}), 0);

        // Reset with three digits seen: stale seen bits must not complete a frame
        show(3, 7'h79, 10); show(2, 7'h24, 10); show(1, 7'h30, 10);
        reset = 1'b1;
        idle(2);
        chk("mid_rst_value", 32'(value), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_masks", 32'({blank_mask, err_mask}), 0);
        reset = 1'b0;
        fd0 = fd_count;
        show(2, 7'h78, 10); show(1, 7'h00, 10); show(0, 7'h18, 10);
        idle(4);
        chk("post_rst_no_pulse", 32'(fd_count - fd0), 0);
        chk("post_rst_valid", 32'(valid), 0);
        show(3, 7'h02, 10);
        idle(4);
        chk("post_rst_pulses", 32'(fd_count - fd0), 1);
        chk("post_rst_value", 32'(value), 32'h6789);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
